// File: rtl/detect_pkg.sv
// Shared types and next-state function for the multi-channel 1-0-1 sequence detector.
// Latency: none (types and combinational helper only).
// Backpressure: not applicable.
package detect_pkg;

   // Highest channel count the 3-bit channel index and pointer can address.
   localparam int N_CH_MAX = 8;

   typedef enum logic [1:0] {
      ST_A = 2'd0,
      ST_B = 2'd1,
      ST_C = 2'd2,
      ST_D = 2'd3
   } state_t;

   // One detector step. D is reached on the 1 that completes "1,0,1".
   // Overlapping matches are allowed: D behaves like B.
   function automatic state_t next_state(input state_t s, input logic b);
      state_t n;
      case (s)
         ST_A:    n = b ? ST_B : ST_A;
         ST_B:    n = b ? ST_B : ST_C;
         ST_C:    n = b ? ST_D : ST_A;
         default: n = b ? ST_B : ST_C;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/detect_sched_if.sv
// Serial input handshake bundle: per-channel valid/bit from the requesters, one-hot ready back.
// Latency: wires only.
// Backpressure: a requester holds in_valid and in_bit until its in_ready bit is seen high.
interface detect_sched_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] in_valid;   // channel i presents a bit
   logic [N_CH-1:0] in_bit;     // serial data bit of channel i
   logic [N_CH-1:0] in_ready;   // one-hot-or-zero grant

   modport master (output in_valid, output in_bit, input  in_ready);
   modport slave  (input  in_valid, input  in_bit, output in_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after i_ptr, wrapping modulo N_CH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ungranted requests simply see no grant.
// Ports: i_req request vector, i_ptr search start, o_gnt one-hot grant, o_gnt_idx grant index,
//        o_gnt_vld any grant issued.
module rr_arbiter #(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0] i_req,
   input  logic [2:0]      i_ptr,
   output logic [N_CH-1:0] o_gnt,
   output logic [2:0]      o_gnt_idx,
   output logic            o_gnt_vld
);

   // Pick the requester with the smallest forward distance from the pointer.
   always_comb begin
      int w_best_d;
      int w_d;
      w_best_d  = N_CH;
      w_d       = 0;
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_gnt_vld = 1'b0;
      for (int j = 0; j < N_CH; j++) begin
         w_d = (j + N_CH - int'(i_ptr)) % N_CH;
         if (i_req[j] && (w_d < w_best_d)) begin
            w_best_d  = w_d;
            o_gnt     = '0;
            o_gnt[j]  = 1'b1;
            o_gnt_idx = 3'(j);
            o_gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/detect_sched.sv
// N_CH serial channels time-share one 1-0-1 detector step; a round-robin grant picks one bit per cycle.
// Latency: match_valid/match_ch one cycle after the completing transfer; det follows registered state.
// Backpressure: in_ready is a one-hot grant; an ungranted requester holds its bit, nothing is buffered.
// Ports: clk, reset_n (async, active-low); bus (valid/bit/ready handshake); ch_en per-channel enable;
//        clr per-channel sync clear; det state-D flags; match_valid/match_ch match pulse; cnt flat
//        per-channel saturating match counters, channel 0 in the LSBs.
module detect_sched
   import detect_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   detect_sched_if.slave         bus,
   input  logic [N_CH-1:0]       ch_en,
   input  logic [N_CH-1:0]       clr,
   output logic [N_CH-1:0]       det,
   output logic                  match_valid,
   output logic [2:0]            match_ch,
   output logic [N_CH*CNT_W-1:0] cnt
);

   state_t           r_state [N_CH];
   logic [CNT_W-1:0] r_cnt   [N_CH];
   logic [2:0]       r_ptr;

   logic [N_CH-1:0]  w_req;
   logic [N_CH-1:0]  w_gnt;
   logic [2:0]       w_gnt_idx;
   logic             w_gnt_vld;
   logic [N_CH-1:0]  w_hit;
   state_t           w_nxt   [N_CH];

   // A channel being cleared is never granted, so its bit is not consumed.
   assign w_req = bus.in_valid & ch_en & ~clr;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .i_req     (w_req),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_vld (w_gnt_vld)
   );

   // Grant is suppressed while in reset so no requester believes its bit was taken.
   assign bus.in_ready = {N_CH{reset_n}} & w_gnt;

   always_comb begin
      w_hit = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_nxt[i] = next_state(r_state[i], bus.in_bit[i]);
         w_hit[i] = w_gnt[i] && (w_nxt[i] == ST_D);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_CH; i++) begin
            r_state[i] <= ST_A;
            r_cnt[i]   <= '0;
         end
         r_ptr       <= '0;
         match_valid <= 1'b0;
         match_ch    <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (clr[i]) begin
               r_state[i] <= ST_A;
               r_cnt[i]   <= '0;
            end else if (w_gnt[i]) begin
               r_state[i] <= w_nxt[i];
               // Saturate rather than wrap.
               if (w_hit[i] && (r_cnt[i] != '1))
                  r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
         if (w_gnt_vld)
            r_ptr <= (w_gnt_idx == 3'(N_CH - 1)) ? 3'd0 : (w_gnt_idx + 3'd1);
         match_valid <= |w_hit;
         if (|w_hit)
            match_ch <= w_gnt_idx;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_out
      assign det[i]                    = (r_state[i] == ST_D);
      assign cnt[i*CNT_W +: CNT_W]     = r_cnt[i];
   end

endmodule

// File: tb/tb_detect_sched.sv
// Directed bench for detect_sched: reset, single-channel match, round-robin order, interleaving,
// clear-at-grant, counter saturation (second instance with CNT_W=2) and asynchronous mid-stream reset.
// Inputs are driven just after a rising edge; outputs are sampled 1 time unit after an edge.
module tb_detect_sched;
   import detect_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   detect_sched_if #(.N_CH(4)) bus0 ();
   detect_sched_if #(.N_CH(4)) bus1 ();

   logic [3:0]  ch_en0, clr0, det0;
   logic        mv0;
   logic [2:0]  mch0;
   logic [31:0] cnt0;

   logic [3:0]  ch_en1, clr1, det1;
   logic        mv1;
   logic [2:0]  mch1;
   logic [7:0]  cnt1;

   detect_sched #(.N_CH(4), .CNT_W(8)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .ch_en(ch_en0), .clr(clr0),
      .det(det0), .match_valid(mv0), .match_ch(mch0), .cnt(cnt0)
   );

   detect_sched #(.N_CH(4), .CNT_W(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .ch_en(ch_en1), .clr(clr1),
      .det(det1), .match_valid(mv1), .match_ch(mch1), .cnt(cnt1)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int xfer [4];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] seq3 [3];
      seq3[0] = 3'd1; seq3[1] = 3'd0; seq3[2] = 3'd1;

      bus0.in_valid = 4'b1100; bus0.in_bit = '0; ch_en0 = 4'hF; clr0 = '0;
      bus1.in_valid = '0;      bus1.in_bit = '0; ch_en1 = 4'hF; clr1 = '0;

      // Reset values, with requests already pending.
      #7;
      chk("rst_det",    32'(det0), 0);
      chk("rst_mv",     32'(mv0),  0);
      chk("rst_mch",    32'(mch0), 0);
      chk("rst_cnt",    cnt0,      0);
      chk("rst_ready",  32'(bus0.in_ready), 0);
      #15;                                   // t=22, between edges
      reset_n = 1'b1;
      #1;
      chk("first_gnt", 32'(bus0.in_ready), 32'b0100);
      bus0.in_valid = '0;
      tick();

      // Channel 0 alone sends 1,0,1.
      bus0.in_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         bus0.in_bit = {3'b000, seq3[k][0]};
         #1;
         chk("t1_gnt", 32'(bus0.in_ready), 32'b0001);
         tick();
      end
      chk("t1_mv",   32'(mv0),      1);
      chk("t1_mch",  32'(mch0),     0);
      chk("t1_det",  32'(det0),     32'b0001);
      chk("t1_cnt",  32'(cnt0[7:0]), 1);
      bus0.in_valid = '0;
      tick();
      chk("t1_pulse_end", 32'(mv0), 0);
      chk("t1_cnt_hold",  32'(cnt0[7:0]), 1);
      clr0 = 4'b0001;
      tick();
      clr0 = '0;
      chk("t1_clr_det", 32'(det0), 0);
      chk("t1_clr_cnt", cnt0, 0);

      // Fresh reset, then all four channels request for 8 cycles.
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      bus0.in_valid = 4'hF; bus0.in_bit = '0;
      for (int i = 0; i < 4; i++) xfer[i] = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_gnt", 32'(bus0.in_ready), 32'(1 << (k % 4)));
         for (int i = 0; i < 4; i++) xfer[i] += int'(bus0.in_ready[i] & bus0.in_valid[i]);
         tick();
      end
      bus0.in_valid = '0;
      for (int i = 0; i < 4; i++) chk("rr_xfer", 32'(xfer[i]), 2);

      // Channel 1 sends 1,0 while channel 2 interleaves 1,1.
      bus0.in_valid = 4'b0110; bus0.in_bit = 4'b0110;
      #1; chk("il_gnt0", 32'(bus0.in_ready), 32'b0010); tick();
      bus0.in_bit = 4'b0100;
      #1; chk("il_gnt1", 32'(bus0.in_ready), 32'b0100); tick();
      #1; chk("il_gnt2", 32'(bus0.in_ready), 32'b0010); tick();
      bus0.in_valid = 4'b0100;
      #1; chk("il_gnt3", 32'(bus0.in_ready), 32'b0100); tick();
      bus0.in_valid = '0;
      chk("il_st1", 32'(dut0.r_state[1]), 32'(ST_C));
      chk("il_st2", 32'(dut0.r_state[2]), 32'(ST_B));
      chk("il_st0", 32'(dut0.r_state[0]), 32'(ST_A));
      chk("il_st3", 32'(dut0.r_state[3]), 32'(ST_A));

      // Channel 3 matches, then is cleared in the cycle it would be granted.
      bus0.in_valid = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         bus0.in_bit = {seq3[k][0], 3'b000};
         #1;
         chk("c3_gnt", 32'(bus0.in_ready), 32'b1000);
         tick();
      end
      chk("c3_mv",  32'(mv0),  1);
      chk("c3_mch", 32'(mch0), 3);
      chk("c3_det", 32'(det0), 32'b1000);
      chk("c3_cnt", 32'(cnt0[31:24]), 1);
      bus0.in_valid = 4'b0100; bus0.in_bit = '0;
      #1; chk("c2_gnt", 32'(bus0.in_ready), 32'b0100); tick();
      bus0.in_valid = 4'b1001; bus0.in_bit = 4'b1001; clr0 = 4'b1000;
      #1; chk("clr_gnt", 32'(bus0.in_ready), 32'b0001); tick();
      clr0 = '0; bus0.in_valid = '0;
      chk("clr_st3",  32'(dut0.r_state[3]), 32'(ST_A));
      chk("clr_cnt3", 32'(cnt0[31:24]), 0);
      chk("clr_det",  32'(det0), 0);
      chk("clr_st0",  32'(dut0.r_state[0]), 32'(ST_B));
      chk("clr_st2",  32'(dut0.r_state[2]), 32'(ST_C));

      // CNT_W=2 instance: five matches saturate the counter at 3.
      bus1.in_valid = 4'b0001;
      for (int k = 0; k < 11; k++) begin
         bus1.in_bit = {3'b000, ((k % 2) == 0)};
         tick();
         chk("sat_mv",  32'(mv1), 32'((k >= 2) && ((k % 2) == 0)));
         chk("sat_cnt", 32'(cnt1[1:0]), 32'(((k / 2) > 3) ? 3 : (k / 2)));
      end
      bus1.in_valid = '0;
      chk("sat_det", 32'(det1), 32'b0001);

      // Channel 0 to state C, then asynchronous reset between edges before the completing bit lands.
      bus0.in_valid = 4'b0001; bus0.in_bit = 4'b0000;
      tick();
      chk("ar_stC", 32'(dut0.r_state[0]), 32'(ST_C));
      bus0.in_bit = 4'b0001;
      #3;
      reset_n = 1'b0;
      #1;
      chk("ar_mv",    32'(mv0),  0);
      chk("ar_det",   32'(det0), 0);
      chk("ar_ready", 32'(bus0.in_ready), 0);
      chk("ar_st0",   32'(dut0.r_state[0]), 32'(ST_A));
      tick();
      chk("ar_mv_hold", 32'(mv0), 0);
      bus0.in_valid = '0;
      reset_n = 1'b1;
      tick();
      chk("ar_no_pulse", 32'(mv0), 0);
      chk("ar_cnt",      cnt0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/detect_sched.md
DETECT_SCHED -- requirements
Module: detect_sched

Interface
REQ-001 Parameter N_CH, default 4, sets the number of serial input channels sharing one detector next-state function (range 2..8).
REQ-002 Parameter CNT_W, default 8, sets the width of each per-channel match counter.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  is the reset: asynchronous and active-low.
REQ-005 Port in_valid  input  N_CH  flags that channel i presents a bit.
REQ-006 Port in_bit  input  N_CH  carries the serial data bit of channel i.
REQ-007 Port in_ready  output  N_CH  is a one-hot-or-zero grant; a transfer on channel i occurs when in_valid[i] and in_ready[i] are both high.
REQ-008 Port ch_en  input  N_CH  enables channel i for arbitration.
REQ-009 Port clr  input  N_CH  synchronously clears the state and counter of channel i.
REQ-010 Port det  output  N_CH  is high while channel i's stored state is D.
REQ-011 Port match_valid  output  1  is a one-cycle pulse reporting a completed match.
REQ-012 Port match_ch  output  3  is the channel index of the reported match, valid only with match_valid.
REQ-013 Port cnt  output  N_CH*CNT_W  is the flat concatenation of the per-channel match counters, with channel 0 in the LSBs.

Function
REQ-014 Each channel keeps a 2-bit state from {A=0, B=1, C=2, D=3}.
REQ-015 On a transfer, the transferring channel's state advances as follows:
- A: in ? B : A
- B: in ? B : C
- C: in ? D : A
- D: in ? B : C
REQ-016 The eligible set is channels with in_valid=1, ch_en=1 and clr=0.
REQ-017 in_ready is combinational: it grants the first eligible channel at or after rr_ptr, searching upward modulo N_CH.
REQ-018 At most one transfer occurs per cycle.
REQ-019 After a transfer on channel g, rr_ptr becomes (g+1) mod N_CH; with no transfer, rr_ptr holds.
REQ-020 When a transfer's next state is D, match_valid=1 and match_ch=g are driven in the following cycle (latency 1); otherwise match_valid=0.
REQ-021 In the same edge as a match, cnt[g] increments; it saturates at 2^CNT_W-1 and never wraps.
REQ-022 clr[i]=1 sets state[i] to A and cnt[i] to 0 at the next edge, and channel i is not granted that cycle.
REQ-023 clr on one channel does not affect the other channels.
REQ-024 ch_en[i]=0 freezes state[i] and cnt[i] and withholds in_ready[i].
REQ-025 det[i] is a Moore output decoded from the registered state[i] only.
REQ-026 A valid without ready holds no internal data; the requester keeps in_bit stable until granted.

Reset
REQ-027 While reset_n=0, every state is A, every cnt is 0, rr_ptr=0, match_valid=0, match_ch=0 and det=0.
REQ-028 in_ready is 0 while reset_n=0.
REQ-029 Asserting reset_n low mid-stream discards any in-flight match pulse.
REQ-030 The first grant after reset_n rises goes to the lowest-index eligible channel.

Structure
REQ-031 Package detect_pkg holds:
- the state typedef (A/B/C/D encodings)
- the next-state function
- the N_CH upper bound constant
REQ-032 The round-robin arbiter is a sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, grant index).
REQ-033 Per-channel state and counters are register arrays in detect_sched; there is no per-channel FSM instance.

Verification
REQ-034 Channel 0 alone sends 1,0,1 -> match_valid=1 and match_ch=0 one cycle after the third transfer; det[0]=1; cnt[0]=1.
REQ-035 Channels 0-3 all hold in_valid=1 for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, each channel transferring exactly twice.
REQ-036 Channel 1 sends 1,0 while channel 2 interleaves 1,1 -> channel 1 reaches C, channel 2 reaches B, and the states do not cross-contaminate.
REQ-037 With CNT_W=2, channel 0 completes 5 matches (1,0,1,0,1,0,1,0,1,0,1) -> cnt[0] saturates at 3.
REQ-038 Assert clr[3] in the same cycle channel 3 would be granted -> in_ready[3]=0, state[3]=A, cnt[3]=0, and the grant passes to the next eligible channel.
REQ-039 Pull reset_n low asynchronously between edges while channel 0 is in state C -> all outputs reach their reset values immediately, and no match pulse follows.
